par_ser: RTL and testbench

- Parallel-to-serial converter for the 6-phase polyphase FIR path.
- Accepts one 6-word group (phases 6k..6k+5) on a single-cycle valid strobe, matching the par_gen output format. Emits the words one per cycle in phase order (6k first) with a valid/ready handshake toward the downstream serial consumer.
- Two-bank ping-pong buffer, so a new group can arrive while the previous one is still being shifted out.

---
 rtl/par_ser.sv | 119 +++++++++++
 tb/tb_par_ser.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/par_ser.sv
// par_ser: accepts a 6-word polyphase group in one cycle and streams it out word by word,
// using a two-bank ping-pong buffer. Define PAR_SER_PHASE_EN to add the phase_out port.
module par_ser #(
    parameter int w_in = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   valid_in,
    input  logic signed [w_in-1:0] data_in_0,
    input  logic signed [w_in-1:0] data_in_1,
    input  logic signed [w_in-1:0] data_in_2,
    input  logic signed [w_in-1:0] data_in_3,
    input  logic signed [w_in-1:0] data_in_4,
    input  logic signed [w_in-1:0] data_in_5,
    input  logic                   out_ready,
    output logic                   valid_out,
    output logic signed [w_in-1:0] data_out,
    output logic                   ovf
`ifdef PAR_SER_PHASE_EN
    ,
    output logic [2:0]             phase_out
`endif
);
    localparam int n_words = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [w_in-1:0] bank_reg [2][n_words];
    logic [1:0]      full_reg, full_next;
    logic            wr_sel_reg, wr_sel_next;
    logic            rd_sel_reg, rd_sel_next;
    logic [2:0]      idx_reg, idx_next;
    logic            ovf_reg, ovf_next;
    logic [w_in-1:0] din [n_words];
    logic            xfer, last, cap, drop;

    assign din[0] = data_in_0;
    assign din[1] = data_in_1;
    assign din[2] = data_in_2;
    assign din[3] = data_in_3;
    assign din[4] = data_in_4;
    assign din[5] = data_in_5;

    assign xfer = (state_reg == SHIFT) && out_ready;
    assign last = xfer && (idx_reg == 3'(n_words - 1));
    // A full write bank is still usable when its final word leaves in this same cycle.
    assign cap  = valid_in && (!full_reg[wr_sel_reg] || (last && (rd_sel_reg == wr_sel_reg)));
    assign drop = valid_in && !cap;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] = (cap && (wr_sel_reg == 1'(gi))) ? 1'b1 :
                                   (last && (rd_sel_reg == 1'(gi))) ? 1'b0 :
                                   full_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            full_reg   <= '0;
            wr_sel_reg <= 1'b0;
            rd_sel_reg <= 1'b0;
            idx_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            full_reg   <= full_next;
            wr_sel_reg <= wr_sel_next;
            rd_sel_reg <= rd_sel_next;
            idx_reg    <= idx_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < n_words; w++) begin
                    bank_reg[b][w] <= '0;
                end
            end
        end else if (cap) begin
            for (int w = 0; w < n_words; w++) begin
                bank_reg[wr_sel_reg][w] <= din[w];
            end
        end
    end

    always_comb begin
        wr_sel_next = cap ? ~wr_sel_reg : wr_sel_reg;
        rd_sel_next = last ? ~rd_sel_reg : rd_sel_reg;
        idx_next    = idx_reg;
        if (xfer) begin
            idx_next = last ? 3'd0 : idx_reg + 3'd1;
        end
        ovf_next   = ovf_reg | drop;
        state_next = full_next[rd_sel_next] ? SHIFT : IDLE;
    end

    always_comb begin
        valid_out = (state_reg == SHIFT);
        data_out  = '0;
        if (state_reg == SHIFT) begin
            data_out = bank_reg[rd_sel_reg][idx_reg];
        end
    end

    assign ovf = ovf_reg;

`ifdef PAR_SER_PHASE_EN
    assign phase_out = (state_reg == SHIFT) ? idx_reg : 3'd0;
`endif

endmodule

// File: tb/tb_par_ser.sv
// Self-checking bench for par_ser: scoreboard of expected words, one task per scenario.
module tb_par_ser;
    localparam int W = 15;

    logic                clk = 1'b0;
    logic                rstn;
    logic                valid_in;
    logic signed [W-1:0] d0, d1, d2, d3, d4, d5;
    logic                out_ready;
    logic                valid_out;
    logic signed [W-1:0] data_out;
    logic                ovf;
`ifdef PAR_SER_PHASE_EN
    logic [2:0]          phase_out;
`endif

    logic [W-1:0] sb [$];
    int n_chk  = 0;
    int n_fail = 0;

    par_ser #(.w_in(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .data_in_0 (d0),
        .data_in_1 (d1),
        .data_in_2 (d2),
        .data_in_3 (d3),
        .data_in_4 (d4),
        .data_in_5 (d5),
        .out_ready (out_ready),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ovf       (ovf)
`ifdef PAR_SER_PHASE_EN
        ,
        .phase_out (phase_out)
`endif
    );

    always #5 clk = ~clk;

    // Drives one group for the coming edge; kept groups go to the scoreboard.
    task automatic strobe(input int v0, input int v1, input int v2, input int v3,
                          input int v4, input int v5, input bit keep);
        valid_in = 1'b1;
        d0 = W'(v0); d1 = W'(v1); d2 = W'(v2);
        d3 = W'(v3); d4 = W'(v4); d5 = W'(v5);
        if (keep) begin
            sb.push_back(W'(v0)); sb.push_back(W'(v1)); sb.push_back(W'(v2));
            sb.push_back(W'(v3)); sb.push_back(W'(v4)); sb.push_back(W'(v5));
        end
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        out_ready = 1'b1;
        strobe(7, 7, 7, 7, 7, 7, 1'b0);
        repeat (2) @(negedge clk);
        n_chk++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: valid_out=%b required 0", valid_out); end
        n_chk++;
        if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: data_out=%0d required 0", data_out); end
        n_chk++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: ovf=%b required 0", ovf); end
        rstn     = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        n_chk++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_no_capture: valid_out=%b required 0", valid_out); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic         exp_v;
        logic [W-1:0] exp_d;
        for (int c = 0; c < 8; c++) begin
            valid_in  = 1'b0;
            out_ready = 1'b1;
            if (c == 0) strobe(1, 2, 3, 4, 5, -6, 1'b1);
            exp_v = (c >= 1 && c <= 6);
            n_chk++;
            if (valid_out !== exp_v) begin n_fail++; $display("FAIL single_valid c=%0d: valid_out=%b required %b", c, valid_out, exp_v); end
            if (!exp_v) begin
                n_chk++;
                if (data_out !== '0) begin n_fail++; $display("FAIL single_idle_data c=%0d: data_out=%0d required 0", c, data_out); end
            end
`ifdef PAR_SER_PHASE_EN
            n_chk++;
            if (phase_out !== (exp_v ? 3'(c - 1) : 3'd0)) begin
                n_fail++; $display("FAIL single_phase c=%0d: phase_out=%0d required %0d", c, phase_out, exp_v ? c - 1 : 0);
            end
`endif
            if (valid_out === 1'b1 && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL single_data c=%0d: data_out=%0d with empty scoreboard", c, data_out); end
                else begin
                    exp_d = sb.pop_front();
                    if (data_out !== exp_d) begin n_fail++; $display("FAIL single_data c=%0d: data_out=%0d required %0d", c, data_out, $signed(exp_d)); end
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL single_ovf: ovf=%b required 0", ovf); end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d words left, required 0", sb.size()); end
        $display("test_single done");
    endtask

    // Strobes at the cycles listed; valid_out must be high for cycles 1..last_valid.
    task automatic test_stream(input string name, input int s0, input int s1, input int s2,
                               input int last_valid);
        logic         exp_v;
        logic [W-1:0] exp_d;
        int           base;
        base = 10;
        for (int c = 0; c <= last_valid + 1; c++) begin
            valid_in  = 1'b0;
            out_ready = 1'b1;
            if (c == s0 || c == s1 || c == s2) begin
                strobe(base, base + 1, base + 2, base + 3, base + 4, base + 5, 1'b1);
                base += 10;
            end
            exp_v = (c >= 1 && c <= last_valid);
            n_chk++;
            if (valid_out !== exp_v) begin n_fail++; $display("FAIL %s_valid c=%0d: valid_out=%b required %b", name, c, valid_out, exp_v); end
            if (valid_out === 1'b1 && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL %s_data c=%0d: data_out=%0d with empty scoreboard", name, c, data_out); end
                else begin
                    exp_d = sb.pop_front();
                    if (data_out !== exp_d) begin n_fail++; $display("FAIL %s_data c=%0d: data_out=%0d required %0d", name, c, data_out, $signed(exp_d)); end
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL %s_ovf: ovf=%b required 0", name, ovf); end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL %s_drain: %0d words left, required 0", name, sb.size()); end
        $display("test_%s done", name);
    endtask

    task automatic test_backpressure();
        logic         exp_v;
        logic [W-1:0] exp_d;
        logic [W-1:0] hold_d;
        hold_d = W'(10);
        for (int c = 0; c < 28; c++) begin
            valid_in  = 1'b0;
            out_ready = (c >= 21);
            if (c == 0) strobe(10, 11, 12, 13, 14, 15, 1'b1);
            exp_v = (c >= 1 && c <= 26);
            n_chk++;
            if (valid_out !== exp_v) begin n_fail++; $display("FAIL bp_valid c=%0d: valid_out=%b required %b", c, valid_out, exp_v); end
            if (c >= 1 && c <= 20) begin
                n_chk++;
                if (data_out !== hold_d) begin n_fail++; $display("FAIL bp_hold c=%0d: data_out=%0d required %0d", c, data_out, $signed(hold_d)); end
            end
            if (valid_out === 1'b1 && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_data c=%0d: data_out=%0d with empty scoreboard", c, data_out); end
                else begin
                    exp_d = sb.pop_front();
                    if (data_out !== exp_d) begin n_fail++; $display("FAIL bp_data c=%0d: data_out=%0d required %0d", c, data_out, $signed(exp_d)); end
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d words left, required 0", sb.size()); end
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        logic         exp_v;
        logic         exp_o;
        logic [W-1:0] exp_d;
        logic [W-1:0] hold_d;
        hold_d = W'(70);
        for (int c = 0; c < 18; c++) begin
            valid_in  = 1'b0;
            out_ready = (c >= 5);
            if (c == 0) strobe(70, 71, 72, 73, 74, 75, 1'b1);
            if (c == 1) strobe(80, 81, 82, 83, 84, 85, 1'b1);
            if (c == 2) strobe(90, 91, 92, 93, 94, 95, 1'b0);
            exp_v = (c >= 1 && c <= 16);
            exp_o = (c >= 3);
            n_chk++;
            if (valid_out !== exp_v) begin n_fail++; $display("FAIL ovf_valid c=%0d: valid_out=%b required %b", c, valid_out, exp_v); end
            n_chk++;
            if (ovf !== exp_o) begin n_fail++; $display("FAIL ovf_flag c=%0d: ovf=%b required %b", c, ovf, exp_o); end
            if (c >= 1 && c <= 4) begin
                n_chk++;
                if (data_out !== hold_d) begin n_fail++; $display("FAIL ovf_hold c=%0d: data_out=%0d required %0d", c, data_out, $signed(hold_d)); end
            end
            if (valid_out === 1'b1 && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL ovf_data c=%0d: data_out=%0d with empty scoreboard", c, data_out); end
                else begin
                    exp_d = sb.pop_front();
                    if (data_out !== exp_d) begin n_fail++; $display("FAIL ovf_data c=%0d: data_out=%0d required %0d", c, data_out, $signed(exp_d)); end
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL ovf_drain: %0d words left, required 0", sb.size()); end
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid();
        logic         exp_v;
        logic         exp_o;
        logic [W-1:0] exp_d;
        for (int c = 0; c < 14; c++) begin
            valid_in  = 1'b0;
            out_ready = (c != 4);
            rstn      = (c != 4);
            if (c == 4) sb.delete();
            if (c == 0) strobe(10, 11, 12, 13, 14, 15, 1'b1);
            if (c == 6) strobe(30, 31, 32, 33, 34, 35, 1'b1);
            exp_v = (c >= 1 && c <= 4) || (c >= 7 && c <= 12);
            exp_o = (c <= 4);
            n_chk++;
            if (valid_out !== exp_v) begin n_fail++; $display("FAIL rmid_valid c=%0d: valid_out=%b required %b", c, valid_out, exp_v); end
            n_chk++;
            if (ovf !== exp_o) begin n_fail++; $display("FAIL rmid_ovf c=%0d: ovf=%b required %b", c, ovf, exp_o); end
            if (!exp_v) begin
                n_chk++;
                if (data_out !== '0) begin n_fail++; $display("FAIL rmid_idle_data c=%0d: data_out=%0d required 0", c, data_out); end
            end
            if (valid_out === 1'b1 && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rmid_data c=%0d: data_out=%0d with empty scoreboard", c, data_out); end
                else begin
                    exp_d = sb.pop_front();
                    if (data_out !== exp_d) begin n_fail++; $display("FAIL rmid_data c=%0d: data_out=%0d required %0d", c, data_out, $signed(exp_d)); end
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL rmid_drain: %0d words left, required 0", sb.size()); end
        $display("test_reset_mid done");
    endtask

    initial begin
        rstn = 1'b0; valid_in = 1'b0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0; d5 = '0;
        test_reset();
        test_single();
        test_stream("back_to_back", 0, 6, -1, 12);
        test_stream("free_same_cycle", 0, 1, 6, 18);
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
